// File: rtl/exec_pkg.sv
// Shared execution-unit types: writeback entry layout and ALU opcode encodings.
package exec_pkg;
    localparam int RD_W   = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_EQ   = 4'b1011;
endpackage

// File: rtl/alu_result_wb_fifo.sv
// Synchronous FIFO of writeback entries; head is read combinationally from storage.
module wb_fifo
    import exec_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("wb_fifo: push dropped while full");
endmodule

// File: rtl/alu_result_wb.sv
// ALU writeback stage: pairs issued rd with the next-cycle ALU result and queues it.
// Optional macro ZERO_REG_FILTER_EN drops entries targeting x0.
module alu_result_wb
    import exec_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int RD_W   = exec_pkg::RD_W,
    parameter int DATA_W = exec_pkg::DATA_W,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [RD_W-1:0]   issue_rd,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    output logic              issue_stall,
    output logic [CW-1:0]     occupancy
);
    logic            align_valid;
    logic [RD_W-1:0] align_rd;
    logic            push, pop, empty, full;
    wb_entry_t       entry, head;

    always_ff @(posedge clk) begin
        if (rst) begin
            align_valid <= 1'b0;
            align_rd    <= '0;
        end else begin
            align_valid <= issue_valid;
            align_rd    <= issue_rd;
        end
    end

`ifdef ZERO_REG_FILTER_EN
    assign push = align_valid && (align_rd != '0);
`else
    assign push = align_valid;
`endif

    assign entry.rd   = align_rd;
    assign entry.data = alu_result;
    assign pop        = wb_valid && wb_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (occupancy)
    );

    assign wb_valid = !empty;
    assign wb_rd    = head.rd;
    assign wb_data  = head.data;

    // Ignores a same-cycle pop: keeps room for the in-flight entry plus one new issue.
    assign issue_stall = (occupancy + CW'(align_valid)) >= CW'(DEPTH);
endmodule

// File: doc/alu_result_wb.md
Name: alu_result_wb

Overview:
- Writeback stage directly downstream of the execution-unit ALU.
- The ALU registers `result` one clock after its operands and `alu_control` are applied.
- This block tags each result with the destination register issued alongside it. It buffers {rd, result} in a small FIFO and drains it to the register-file write port over a valid/ready handshake.
- It raises `issue_stall` so that no ALU result is ever dropped.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RD_W, 5, destination register index width.
- DATA_W, 32, result width; matches the ALU `result`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  an ALU op is applied this cycle (same cycle as `operand_1`/`operand_2`/`alu_control`).
- issue_rd  in  RD_W  destination register of that op.
- alu_result  in  DATA_W  the ALU `result` output.
- wb_valid  out  1  FIFO head is valid.
- wb_rd  out  RD_W  head destination register.
- wb_data  out  DATA_W  head data.
- wb_ready  in  1  register file accepts the head this cycle.
- issue_stall  out  1  upstream must not assert issue_valid this cycle.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (rst=1 at posedge):
  - align_valid=0, align_rd=0.
  - FIFO rd/wr pointers=0, occupancy=0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - issue_stall=0.
  - Any in-flight op is discarded.
- Alignment register: at posedge, align_valid<=issue_valid and align_rd<=issue_rd. An op issued in cycle N is therefore paired with alu_result during cycle N+1.
- Push: push=align_valid in cycle N+1; the entry {align_rd, alu_result} is written at the end of N+1.
- Pop: pop=wb_valid & wb_ready; the head advances at posedge.
- Output timing:
  - wb_valid = (occupancy!=0).
  - wb_rd/wb_data come from the head entry, driven combinationally from FIFO storage.
  - No bypass: minimum issue-to-wb_valid latency is 2 cycles.
- Simultaneous push and pop:
  - Legal at any occupancy, including full; occupancy is unchanged.
  - When occupancy==1, the pop reads the old head and the new entry becomes the head next cycle.
- Stall rule, combinational: issue_stall = (occupancy + align_valid) >= DEPTH.
  - This is conservative: it ignores a same-cycle pop.
  - It guarantees room for the in-flight aligned entry plus one new issue.
- Overflow:
  - Must not occur if upstream honours issue_stall.
  - If issue_valid arrives while stalled anyway, the entry is still aligned. Its push when full is dropped, pointers are not corrupted, and an assertion fires in simulation.
- Underflow: pop with occupancy 0 is impossible because wb_valid=0.
- Pointers: RD_W-independent, $clog2(DEPTH) bits, wrap naturally.
- Ordering: strictly in issue order.
- wb_rd/wb_data stay stable while wb_valid=1 and wb_ready=0.

Optional Feature:
- Macro: ZERO_REG_FILTER_EN.
- Defined: an aligned op with align_rd==0 is not pushed, since x0 is hard-wired. It does not occupy the FIFO, and the stall rule still counts align_valid, so stalls are conservative.
- Undefined: rd==0 entries are pushed and written back like any other.

Decomposition:
- Shared package `exec_pkg`:
  - localparams RD_W=5, DATA_W=32.
  - typedef struct packed {logic [RD_W-1:0] rd; logic [DATA_W-1:0] data;} wb_entry_t.
  - ALU opcode constants (ALU_ADD=4'b0001 … ALU_EQ=4'b1011) for shared use by issue/ALU/benches.
- One sub-module, `wb_fifo`: a parameterised synchronous FIFO of wb_entry_t with push/pop/occupancy.
- The top holds the alignment register, stall logic and filter.

Test Plan:
- Single op: issue rd=3 with ALU computing 1+0x12 → cycle N+2 shows wb_valid=1, wb_rd=3, wb_data=0x13; pops next cycle with wb_ready=1.
- Back-to-back: 4 issues (rd=1..4, results 0x13, 0xFFFFFFEF (sub), 0x0, 0x1), wb_ready=0 → occupancy reaches 4, issue_stall=1 from occupancy 3 with align_valid=1; draining yields the same order and values.
- Simultaneous push/pop at full: occupancy=4, wb_ready=1, align_valid=1 → occupancy stays 4, head advances, no loss.
- Reset mid-operation: occupancy=3 and align_valid=1, rst=1 for 1 cycle → next cycle occupancy=0, wb_valid=0, issue_stall=0, and the in-flight result never appears.
- Backpressure stability: wb_ready toggles 0/1 each cycle over 6 entries → wb_rd/wb_data stable while stalled, all 6 delivered in order.
- ZERO_REG_FILTER_EN: issue rd=0 then rd=7 → defined: only rd=7 appears; undefined: both appear in order.
